// File: rtl/uart_core_param_if.sv
// Host-side handshake and pin bundle for uart_core_param.
// The slave modport is the UART's view, the master modport the host's view.
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 uart_rx;
  logic                 uart_tx;
  logic [2:0]           error_flags;
  logic                 err_clear;

  modport slave (
    input  tx_data, tx_valid, rx_ready, uart_rx, err_clear,
    output tx_ready, rx_data, rx_valid, uart_tx, error_flags
  );

  modport master (
    output tx_data, tx_valid, rx_ready, uart_rx, err_clear,
    input  tx_ready, rx_data, rx_valid, uart_tx, error_flags
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable width/parity/stop, 16x oversampled RX
// with start-bit glitch rejection, valid/ready handshakes and sticky error flags.
module uart_core_param #(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  uart_core_param_if.slave   bus
);
  localparam int   DIV_W   = $clog2(CLK_DIV);
  localparam int   BIT_CYC = 16 * CLK_DIV;
  localparam int   BT_W    = $clog2(BIT_CYC);
  localparam int   IDX_W   = $clog2(DATA_BITS);
  localparam logic ODD     = (PARITY == 2);
  localparam logic HAS_PAR = (PARITY != 0);

  // ---------------- oversample tick ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + 1'b1;

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_nxt;
  logic [BT_W-1:0]      tx_tmr, tx_tmr_nxt;
  logic [IDX_W-1:0]     tx_idx, tx_idx_nxt;
  logic                 tx_stop, tx_stop_nxt;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic                 tx_par, tx_par_nxt;
  logic                 bit_end;

  // TX has its own bit timer so frames start exactly one cycle after acceptance
  assign bit_end = (tx_tmr == BT_W'(BIT_CYC - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= '0;
      tx_idx   <= '0;
      tx_stop  <= 1'b0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_nxt;
      tx_tmr   <= tx_tmr_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_stop  <= tx_stop_nxt;
      tx_sh    <= tx_sh_nxt;
      tx_par   <= tx_par_nxt;
    end

  always_comb begin
    tx_nxt      = tx_state;
    tx_tmr_nxt  = bit_end ? '0 : tx_tmr + 1'b1;
    tx_idx_nxt  = tx_idx;
    tx_stop_nxt = tx_stop;
    tx_sh_nxt   = tx_sh;
    tx_par_nxt  = tx_par;
    case (tx_state)
      TX_IDLE: begin
        tx_tmr_nxt = '0;
        if (bus.tx_valid) begin
          tx_sh_nxt   = bus.tx_data;
          tx_par_nxt  = (^bus.tx_data) ^ ODD;
          tx_idx_nxt  = '0;
          tx_stop_nxt = 1'b0;
          tx_nxt      = TX_START;
        end
      end
      TX_START: if (bit_end) tx_nxt = TX_DATA;
      TX_DATA: if (bit_end) begin
        tx_sh_nxt = tx_sh >> 1;
        if (tx_idx == IDX_W'(DATA_BITS - 1)) tx_nxt = HAS_PAR ? TX_PAR : TX_STOP;
        else                                 tx_idx_nxt = tx_idx + 1'b1;
      end
      TX_PAR: if (bit_end) tx_nxt = TX_STOP;
      TX_STOP: if (bit_end) begin
        if (tx_stop == 1'(STOP_BITS - 1)) tx_nxt = TX_IDLE;
        else                              tx_stop_nxt = 1'b1;
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.uart_tx  = (tx_state == TX_START) ? 1'b0     :
                        (tx_state == TX_DATA)  ? tx_sh[0] :
                        (tx_state == TX_PAR)   ? tx_par   : 1'b1;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

  logic [1:0]           rx_sync;
  logic                 rx_s;
  rx_state_t            rx_state, rx_nxt;
  logic [3:0]           rx_tcnt, rx_tcnt_nxt;
  logic [IDX_W-1:0]     rx_idx, rx_idx_nxt;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
  logic                 rx_deliver, set_fe, set_pe, set_ov;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic [2:0]           err_q;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], bus.uart_rx};
      rx_state <= rx_nxt;
      rx_tcnt  <= rx_tcnt_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_sh    <= rx_sh_nxt;
    end

  // tick count wraps 15->0 on its own, so each bit is sampled 16 ticks after the last
  always_comb begin
    rx_nxt      = rx_state;
    rx_tcnt_nxt = rx_tcnt;
    rx_idx_nxt  = rx_idx;
    rx_sh_nxt   = rx_sh;
    rx_deliver  = 1'b0;
    set_fe      = 1'b0;
    set_pe      = 1'b0;
    if (tick) begin
      rx_tcnt_nxt = rx_tcnt + 4'd1;
      case (rx_state)
        RX_IDLE: begin
          rx_tcnt_nxt = '0;
          if (!rx_s) rx_nxt = RX_START;
        end
        RX_START: if (rx_tcnt == 4'd7) begin
          rx_tcnt_nxt = '0;
          rx_idx_nxt  = '0;
          rx_nxt      = rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_tcnt == 4'd15) begin
          rx_sh_nxt = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == IDX_W'(DATA_BITS - 1)) rx_nxt = HAS_PAR ? RX_PAR : RX_STOP;
          else                                 rx_idx_nxt = rx_idx + 1'b1;
        end
        RX_PAR: if (rx_tcnt == 4'd15) begin
          set_pe = (rx_s != ((^rx_sh) ^ ODD));
          rx_nxt = RX_STOP;
        end
        RX_STOP: if (rx_tcnt == 4'd15) begin
          if (rx_s) begin
            rx_deliver = 1'b1;
            rx_nxt     = RX_IDLE;
          end else begin
            set_fe = 1'b1;
            rx_nxt = RX_WAIT;
          end
        end
        RX_WAIT: begin
          rx_tcnt_nxt = '0;
          if (rx_s) rx_nxt = RX_IDLE;
        end
        default: rx_nxt = RX_IDLE;
      endcase
    end
  end

  assign set_ov = rx_deliver && rx_valid_q && !bus.rx_ready;

  // a word consumed in the delivery cycle frees the slot for the new one
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (rx_deliver && (!rx_valid_q || bus.rx_ready)) begin
        rx_data_q  <= rx_sh;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      err_q <= (bus.err_clear ? 3'b000 : err_q) | {set_ov, set_pe, set_fe};
    end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.error_flags = err_q;
endmodule
